// File: rtl/iir_biquad_scheduler.sv
// iir_biquad_scheduler
// One shared direct-form-I biquad MAC datapath serving N_CHANNELS_P channels.
// Each channel owns its history (x1, x2, y1, y2) plus a shadow and an active
// coefficient bank. Shadow banks are written at any time; commits and history
// clears are recorded as pending flags and applied only while the scheduler is
// idle, so a sample in flight always sees one consistent coefficient set.

module iir_biquad_scheduler #(
    parameter int N_CHANNELS_P = 4,
    parameter int DATA_WIDTH_P = 24,
    parameter int COEF_WIDTH_P = 24,
    parameter int Q_BITS_P     = 20,
    localparam int CH_W = (N_CHANNELS_P > 1) ? $clog2(N_CHANNELS_P) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ingress_valid,
    output logic                           ingress_ready,
    input  logic signed [DATA_WIDTH_P-1:0] ingress_data,
    input  logic        [CH_W-1:0]         ingress_channel,
    output logic                           egress_valid,
    input  logic                           egress_ready,
    output logic signed [DATA_WIDTH_P-1:0] egress_data,
    output logic        [CH_W-1:0]         egress_channel,
    input  logic                           cfg_wr,
    input  logic        [CH_W-1:0]         cfg_channel,
    input  logic        [2:0]              cfg_index,
    input  logic signed [COEF_WIDTH_P-1:0] cfg_data,
    input  logic                           cfg_commit,
    input  logic                           cfg_clear,
    output logic                           ingress_error
);

    localparam int PROD_W   = DATA_WIDTH_P + COEF_WIDTH_P;
    localparam int ACC_W    = DATA_WIDTH_P + COEF_WIDTH_P + 3;
    localparam int N_COEF_C = 5;

    localparam logic signed [COEF_WIDTH_P-1:0] UNITY_C  = COEF_WIDTH_P'(1'b1) << Q_BITS_P;
    localparam logic signed [COEF_WIDTH_P-1:0] CZERO_C  = {COEF_WIDTH_P{1'b0}};
    localparam logic signed [DATA_WIDTH_P-1:0] DZERO_C  = {DATA_WIDTH_P{1'b0}};
    localparam logic signed [DATA_WIDTH_P-1:0] Y_MAX_C  = {1'b0, {(DATA_WIDTH_P-1){1'b1}}};
    localparam logic signed [DATA_WIDTH_P-1:0] Y_MIN_C  = {1'b1, {(DATA_WIDTH_P-1){1'b0}}};
    localparam logic signed [ACC_W-1:0]        SAT_MAX_C = ACC_W'(Y_MAX_C);
    localparam logic signed [ACC_W-1:0]        SAT_MIN_C = ACC_W'(Y_MIN_C);
    localparam logic signed [ACC_W-1:0]        RND_C     = ACC_W'(1'b1) << (Q_BITS_P - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_SCALE = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t state_r;
    state_t state_s;

    // Per-channel storage
    logic signed [COEF_WIDTH_P-1:0] coef_shd_r [N_CHANNELS_P][N_COEF_C];
    logic signed [COEF_WIDTH_P-1:0] coef_act_r [N_CHANNELS_P][N_COEF_C];
    logic signed [DATA_WIDTH_P-1:0] x1_r [N_CHANNELS_P];
    logic signed [DATA_WIDTH_P-1:0] x2_r [N_CHANNELS_P];
    logic signed [DATA_WIDTH_P-1:0] y1_r [N_CHANNELS_P];
    logic signed [DATA_WIDTH_P-1:0] y2_r [N_CHANNELS_P];
    logic [N_CHANNELS_P-1:0] commit_pend_r;
    logic [N_CHANNELS_P-1:0] clear_pend_r;
    logic [N_CHANNELS_P-1:0] commit_eff_s;
    logic [N_CHANNELS_P-1:0] clear_eff_s;

    // Datapath
    logic [2:0]                     step_r;
    logic [CH_W-1:0]                ch_r;
    logic signed [DATA_WIDTH_P-1:0] x_r;
    logic signed [ACC_W-1:0]        acc_r;
    logic signed [DATA_WIDTH_P-1:0] mac_opnd_s;
    logic signed [COEF_WIDTH_P-1:0] mac_coef_s;
    logic                           mac_sub_s;
    logic signed [PROD_W-1:0]       mac_prod_s;
    logic signed [ACC_W-1:0]        mac_prod_ext_s;
    logic signed [ACC_W-1:0]        rnd_sum_s;
    logic signed [ACC_W-1:0]        shr_s;
    logic signed [DATA_WIDTH_P-1:0] sat_s;

    // Output registers
    logic                           ingress_ready_r;
    logic                           egress_valid_r;
    logic signed [DATA_WIDTH_P-1:0] egress_data_r;
    logic [CH_W-1:0]                egress_channel_r;
    logic                           ingress_error_r;

    logic ing_ch_ok_s;
    logic cfg_ch_ok_s;
    logic idle_s;
    logic accept_s;
    logic start_s;
    logic handshake_s;

    // Channel ids can only be out of range when N_CHANNELS_P is not a power of two.
    generate
        if (N_CHANNELS_P == (1 << CH_W)) begin : g_full_range
            assign ing_ch_ok_s = 1'b1;
            assign cfg_ch_ok_s = 1'b1;
        end else begin : g_part_range
            assign ing_ch_ok_s = (ingress_channel < CH_W'(N_CHANNELS_P));
            assign cfg_ch_ok_s = (cfg_channel < CH_W'(N_CHANNELS_P));
        end
    endgenerate

    assign idle_s      = (state_r == ST_IDLE);
    assign accept_s    = idle_s & ingress_valid;
    assign start_s     = accept_s & ing_ch_ok_s;
    assign handshake_s = (state_r == ST_OUT) & egress_ready;

    assign ingress_ready  = ingress_ready_r;
    assign egress_valid   = egress_valid_r;
    assign egress_data    = egress_data_r;
    assign egress_channel = egress_channel_r;
    assign ingress_error  = ingress_error_r;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state: IDLE -> MAC (5 steps) -> SCALE -> OUT -> IDLE on handshake
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_s = ST_MAC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (step_r == 3'd4) begin
                    state_s = ST_SCALE;
                end else begin
                    state_s = ST_MAC;
                end
            end
            ST_SCALE: begin
                state_s = ST_OUT;
            end
            ST_OUT: begin
                if (egress_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Effective flags: stored pending flags merged with this cycle's requests
    always_comb begin
        commit_eff_s = {N_CHANNELS_P{1'b0}};
        clear_eff_s  = {N_CHANNELS_P{1'b0}};
        for (int i = 0; i < N_CHANNELS_P; i++) begin
            commit_eff_s[i] = commit_pend_r[i] |
                              (cfg_commit & cfg_ch_ok_s & (cfg_channel == CH_W'(i)));
            clear_eff_s[i]  = clear_pend_r[i] |
                              (cfg_clear & cfg_ch_ok_s & (cfg_channel == CH_W'(i)));
        end
    end

    // Pending flags: consumed in any idle cycle, accumulated while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_pend_r <= {N_CHANNELS_P{1'b0}};
            clear_pend_r  <= {N_CHANNELS_P{1'b0}};
        end else if (idle_s) begin
            commit_pend_r <= {N_CHANNELS_P{1'b0}};
            clear_pend_r  <= {N_CHANNELS_P{1'b0}};
        end else begin
            commit_pend_r <= commit_eff_s;
            clear_pend_r  <= clear_eff_s;
        end
    end

    // Shadow coefficient bank: software writes land immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CHANNELS_P; i++) begin
                for (int k = 0; k < N_COEF_C; k++) begin
                    coef_shd_r[i][k] <= (k == 0) ? UNITY_C : CZERO_C;
                end
            end
        end else if (cfg_wr && cfg_ch_ok_s && (cfg_index < 3'd5)) begin
            coef_shd_r[cfg_channel][cfg_index] <= cfg_data;
        end else begin
            coef_shd_r <= coef_shd_r;
        end
    end

    // Active coefficient bank: whole-bank copy from shadow, only while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CHANNELS_P; i++) begin
                for (int k = 0; k < N_COEF_C; k++) begin
                    coef_act_r[i][k] <= (k == 0) ? UNITY_C : CZERO_C;
                end
            end
        end else if (idle_s) begin
            for (int i = 0; i < N_CHANNELS_P; i++) begin
                if (commit_eff_s[i]) begin
                    for (int k = 0; k < N_COEF_C; k++) begin
                        coef_act_r[i][k] <= coef_shd_r[i][k];
                    end
                end
            end
        end else begin
            coef_act_r <= coef_act_r;
        end
    end

    // History: shifted on the egress handshake, zeroed by an idle-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CHANNELS_P; i++) begin
                x1_r[i] <= DZERO_C;
                x2_r[i] <= DZERO_C;
                y1_r[i] <= DZERO_C;
                y2_r[i] <= DZERO_C;
            end
        end else if (handshake_s) begin
            x2_r[ch_r] <= x1_r[ch_r];
            x1_r[ch_r] <= x_r;
            y2_r[ch_r] <= y1_r[ch_r];
            y1_r[ch_r] <= egress_data_r;
        end else if (idle_s) begin
            for (int i = 0; i < N_CHANNELS_P; i++) begin
                if (clear_eff_s[i]) begin
                    x1_r[i] <= DZERO_C;
                    x2_r[i] <= DZERO_C;
                    y1_r[i] <= DZERO_C;
                    y2_r[i] <= DZERO_C;
                end
            end
        end else begin
            x1_r <= x1_r;
        end
    end

    // MAC operand select: step order b0*x, b1*x1, b2*x2, -a1*y1, -a2*y2
    always_comb begin
        mac_opnd_s = DZERO_C;
        mac_coef_s = CZERO_C;
        mac_sub_s  = 1'b0;
        case (step_r)
            3'd0: begin
                mac_opnd_s = x_r;
                mac_coef_s = coef_act_r[ch_r][0];
            end
            3'd1: begin
                mac_opnd_s = x1_r[ch_r];
                mac_coef_s = coef_act_r[ch_r][1];
            end
            3'd2: begin
                mac_opnd_s = x2_r[ch_r];
                mac_coef_s = coef_act_r[ch_r][2];
            end
            3'd3: begin
                mac_opnd_s = y1_r[ch_r];
                mac_coef_s = coef_act_r[ch_r][3];
                mac_sub_s  = 1'b1;
            end
            3'd4: begin
                mac_opnd_s = y2_r[ch_r];
                mac_coef_s = coef_act_r[ch_r][4];
                mac_sub_s  = 1'b1;
            end
            default: begin
                mac_sub_s = 1'b0;
            end
        endcase
        mac_prod_s     = PROD_W'(mac_coef_s) * PROD_W'(mac_opnd_s);
        mac_prod_ext_s = ACC_W'(mac_prod_s);
    end

    // Round half up, drop the fractional bits, clamp to the sample range
    always_comb begin
        rnd_sum_s = acc_r + RND_C;
        shr_s     = rnd_sum_s >>> Q_BITS_P;
        if (shr_s > SAT_MAX_C) begin
            sat_s = Y_MAX_C;
        end else if (shr_s < SAT_MIN_C) begin
            sat_s = Y_MIN_C;
        end else begin
            sat_s = shr_s[DATA_WIDTH_P-1:0];
        end
    end

    // Datapath registers: latch on accept, accumulate during MAC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_r <= 3'd0;
            ch_r   <= {CH_W{1'b0}};
            x_r    <= DZERO_C;
            acc_r  <= {ACC_W{1'b0}};
        end else if (start_s) begin
            step_r <= 3'd0;
            ch_r   <= ingress_channel;
            x_r    <= ingress_data;
            acc_r  <= {ACC_W{1'b0}};
        end else if (state_r == ST_MAC) begin
            step_r <= step_r + 3'd1;
            acc_r  <= mac_sub_s ? (acc_r - mac_prod_ext_s) : (acc_r + mac_prod_ext_s);
        end else begin
            step_r <= step_r;
        end
    end

    // Registered outputs: handshakes follow the next state, result captured in SCALE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ingress_ready_r  <= 1'b1;
            egress_valid_r   <= 1'b0;
            egress_data_r    <= DZERO_C;
            egress_channel_r <= {CH_W{1'b0}};
            ingress_error_r  <= 1'b0;
        end else begin
            ingress_ready_r <= (state_s == ST_IDLE);
            egress_valid_r  <= (state_s == ST_OUT);
            ingress_error_r <= accept_s & ~ing_ch_ok_s;
            if (state_r == ST_SCALE) begin
                egress_data_r    <= sat_s;
                egress_channel_r <= ch_r;
            end else begin
                egress_data_r    <= egress_data_r;
            end
        end
    end

endmodule

// File: tb/tb_iir_biquad_scheduler.sv
// Self-checking bench for iir_biquad_scheduler: directed scenarios plus a
// randomized phase, all checked against a transaction-level arithmetic model.

module tb_iir_biquad_scheduler;

    localparam int N  = 4;
    localparam int D  = 24;
    localparam int C  = 24;
    localparam int Q  = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ingress_valid = 1'b0;
    logic          ingress_ready;
    logic [D-1:0]  ingress_data = '0;
    logic [1:0]    ingress_channel = '0;
    logic          egress_valid;
    logic          egress_ready = 1'b0;
    logic [D-1:0]  egress_data;
    logic [1:0]    egress_channel;
    logic          cfg_wr = 1'b0;
    logic [1:0]    cfg_channel = '0;
    logic [2:0]    cfg_index = '0;
    logic [C-1:0]  cfg_data = '0;
    logic          cfg_commit = 1'b0;
    logic          cfg_clear = 1'b0;
    logic          ingress_error;

    // Second instance with 5 channels so an out-of-range id is expressible
    logic          in_valid5 = 1'b0;
    logic          in_ready5;
    logic [D-1:0]  in_data5 = '0;
    logic [2:0]    in_ch5 = '0;
    logic          eg_valid5;
    logic          eg_ready5 = 1'b1;
    logic [D-1:0]  eg_data5;
    logic [2:0]    eg_ch5;
    logic          cfg_zero5 = 1'b0;
    logic [2:0]    cfg_ch5 = '0;
    logic [2:0]    cfg_idx5 = '0;
    logic [C-1:0]  cfg_data5 = '0;
    logic          err5;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    longint m_shd [N][5];
    longint m_act [N][5];
    longint m_x1 [N], m_x2 [N], m_y1 [N], m_y2 [N];
    bit     m_cpend [N], m_clpend [N];

    iir_biquad_scheduler #(.N_CHANNELS_P(N), .DATA_WIDTH_P(D), .COEF_WIDTH_P(C), .Q_BITS_P(Q)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .ingress_valid(ingress_valid), .ingress_ready(ingress_ready),
        .ingress_data(ingress_data), .ingress_channel(ingress_channel),
        .egress_valid(egress_valid), .egress_ready(egress_ready),
        .egress_data(egress_data), .egress_channel(egress_channel),
        .cfg_wr(cfg_wr), .cfg_channel(cfg_channel), .cfg_index(cfg_index),
        .cfg_data(cfg_data), .cfg_commit(cfg_commit), .cfg_clear(cfg_clear),
        .ingress_error(ingress_error)
    );

    iir_biquad_scheduler #(.N_CHANNELS_P(5), .DATA_WIDTH_P(D), .COEF_WIDTH_P(C), .Q_BITS_P(Q)) u_dut5 (
        .clk(clk), .rst_n(rst_n),
        .ingress_valid(in_valid5), .ingress_ready(in_ready5),
        .ingress_data(in_data5), .ingress_channel(in_ch5),
        .egress_valid(eg_valid5), .egress_ready(eg_ready5),
        .egress_data(eg_data5), .egress_channel(eg_ch5),
        .cfg_wr(cfg_zero5), .cfg_channel(cfg_ch5), .cfg_index(cfg_idx5),
        .cfg_data(cfg_data5), .cfg_commit(cfg_zero5), .cfg_clear(cfg_zero5),
        .ingress_error(err5)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input logic [D-1:0] d);
        return longint'($signed(d));
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 5; k++) begin
                m_shd[i][k] = (k == 0) ? (64'sd1 <<< Q) : 64'sd0;
                m_act[i][k] = m_shd[i][k];
            end
            m_x1[i] = 0; m_x2[i] = 0; m_y1[i] = 0; m_y2[i] = 0;
            m_cpend[i] = 1'b0; m_clpend[i] = 1'b0;
        end
    endfunction

    // y = b0 x + b1 x1 + b2 x2 - a1 y1 - a2 y2, rounded, then clamped
    function automatic longint m_output(input int ch, input longint x);
        longint acc, r;
        acc = m_act[ch][0] * x + m_act[ch][1] * m_x1[ch] + m_act[ch][2] * m_x2[ch]
            - m_act[ch][3] * m_y1[ch] - m_act[ch][4] * m_y2[ch];
        r = (acc + (64'sd1 <<< (Q - 1))) >>> Q;
        if (r > 8388607) r = 8388607;
        if (r < -8388608) r = -8388608;
        return r;
    endfunction

    function automatic void m_apply_pending();
        for (int i = 0; i < N; i++) begin
            if (m_cpend[i]) begin
                for (int k = 0; k < 5; k++) m_act[i][k] = m_shd[i][k];
            end
            if (m_clpend[i]) begin
                m_x1[i] = 0; m_x2[i] = 0; m_y1[i] = 0; m_y2[i] = 0;
            end
            m_cpend[i] = 1'b0; m_clpend[i] = 1'b0;
        end
    endfunction

    task automatic cfg_write(input int ch, input int idx, input longint v);
        cfg_wr = 1'b1; cfg_channel = 2'(ch); cfg_index = 3'(idx); cfg_data = C'(v);
        @(posedge clk); #1;
        cfg_wr = 1'b0;
        if (idx < 5) m_shd[ch][idx] = v;
    endtask

    // Issued while idle, so the DUT applies it on this same edge
    task automatic cfg_pulse(input int ch, input bit is_clear);
        cfg_channel = 2'(ch);
        if (is_clear) begin cfg_clear = 1'b1; m_clpend[ch] = 1'b1; end
        else begin cfg_commit = 1'b1; m_cpend[ch] = 1'b1; end
        @(posedge clk); #1;
        cfg_clear = 1'b0; cfg_commit = 1'b0;
        m_apply_pending();
    endtask

    // One full transaction. use_exp selects a literal expectation over the model.
    // mc_ch >= 0 pulses cfg_commit for that channel while the sample is in MAC.
    task automatic send(input int ch, input longint x, input int stall,
                        input bit use_exp, input longint exp_y, input int mc_ch);
        int lat;
        longint ey;
        lat = 0;
        while (!ingress_ready && lat < 40) begin @(posedge clk); #1; lat++; end
        check("ready_before_send", ingress_ready, 1);
        ingress_valid = 1'b1; ingress_channel = 2'(ch); ingress_data = D'(x);
        ey = use_exp ? exp_y : m_output(ch, x);
        @(posedge clk); #1;
        ingress_valid = 1'b0;
        check("ready_low_busy", ingress_ready, 0);
        lat = 0;
        while (!egress_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
            if (mc_ch >= 0 && lat == 2) begin
                cfg_commit = 1'b1; cfg_channel = 2'(mc_ch); m_cpend[mc_ch] = 1'b1;
            end else begin
                cfg_commit = 1'b0;
            end
        end
        cfg_commit = 1'b0;
        check("latency", lat, 6);
        check("egress_data", sx(egress_data), ey);
        check("egress_channel", egress_channel, ch);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check("stall_valid", egress_valid, 1);
            check("stall_data", sx(egress_data), ey);
            check("stall_ready_low", ingress_ready, 0);
        end
        egress_ready = 1'b1;
        @(posedge clk); #1;
        egress_ready = 1'b0;
        check("valid_drop", egress_valid, 0);
        check("ready_back", ingress_ready, 1);
        m_x2[ch] = m_x1[ch]; m_x1[ch] = x;
        m_y2[ch] = m_y1[ch]; m_y1[ch] = ey;
        m_apply_pending();
    endtask

    initial begin
        int cnt;
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        check("rst_ingress_ready", ingress_ready, 1);
        check("rst_egress_valid", egress_valid, 0);
        check("rst_egress_data", egress_data, 0);
        check("rst_egress_channel", egress_channel, 0);
        check("rst_ingress_error", ingress_error, 0);

        // Passthrough out of reset
        send(0, 1000, 0, 1, 1000, -1);
        send(0, -1000, 0, 1, -1000, -1);

        // FIR on ch1: b0 = b1 = 0.5
        cfg_write(1, 0, 524288);
        cfg_write(1, 1, 524288);
        cfg_pulse(1, 0);
        send(1, 100, 0, 1, 50, -1);
        send(1, 200, 1, 1, 150, -1);
        send(1, 0, 0, 1, 100, -1);

        // Feedback on ch2: y = x + 0.5 y1
        cfg_write(2, 0, 1048576);
        cfg_write(2, 3, -524288);
        cfg_pulse(2, 0);
        send(2, 1024, 0, 1, 1024, -1);
        send(2, 0, 0, 1, 512, -1);
        send(2, 0, 0, 1, 256, -1);
        cfg_pulse(2, 1);
        send(2, 0, 0, 1, 0, -1);

        // Saturation on ch3: gain 2.0
        cfg_write(3, 0, 2097152);
        cfg_pulse(3, 0);
        send(3, 8388607, 0, 1, 8388607, -1);
        send(3, -8388608, 0, 1, -8388608, -1);

        // Deferred commit on ch1 plus a 10-cycle egress stall; ch0 untouched
        cfg_write(1, 0, 1048576);
        cfg_write(1, 1, 0);
        send(1, 400, 10, 1, 200, 1);
        send(1, 10, 0, 1, 10, -1);
        send(0, 1234, 0, 1, 1234, -1);

        // Out-of-range channel on the 5-channel instance
        in_valid5 = 1'b1; in_ch5 = 3'd5; in_data5 = D'(777);
        @(posedge clk); #1;
        in_valid5 = 1'b0;
        check("err_pulse", err5, 1);
        check("err_ready_kept", in_ready5, 1);
        @(posedge clk); #1;
        check("err_one_cycle", err5, 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (eg_valid5) cnt++;
            @(posedge clk); #1;
        end
        check("err_no_egress", cnt, 0);
        in_valid5 = 1'b1; in_ch5 = 3'd4; in_data5 = D'(5);
        @(posedge clk); #1;
        in_valid5 = 1'b0;
        check("ch4_accepted_busy", in_ready5, 0);
        check("ch4_no_error", err5, 0);
        repeat (10) @(posedge clk);
        #1;

        // Reset asserted during MAC
        ingress_valid = 1'b1; ingress_channel = 2'd2; ingress_data = D'(1024);
        @(posedge clk); #1;
        ingress_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", ingress_ready, 1);
        check("midrst_valid", egress_valid, 0);
        check("midrst_data", egress_data, 0);
        check("midrst_channel", egress_channel, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_reset();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (egress_valid) cnt++;
            @(posedge clk); #1;
        end
        check("midrst_no_egress", cnt, 0);
        send(2, 3000, 0, 1, 3000, -1);
        send(1, -42, 0, 1, -42, -1);

        // Randomized phase against the model
        for (int it = 0; it < 80; it++) begin
            int act, ch;
            act = int'($urandom_range(0, 9));
            ch  = int'($urandom_range(0, 3));
            if (act <= 2) begin
                cfg_write(ch, int'($urandom_range(0, 7)),
                          longint'($urandom_range(0, 2097152)) - 1048576);
            end else if (act == 3) begin
                cfg_pulse(ch, 0);
            end else if (act == 4) begin
                cfg_pulse(ch, 1);
            end else begin
                send(ch, longint'($urandom_range(0, 16777215)) - 8388608,
                     int'($urandom_range(0, 3)), 0, 0, -1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
